csa_acc_seq: RTL and testbench

Sequencer for the 93-bit carry-save adder (`csa_93`) in the 89x89 multiplier datapath. It accepts a programmed number of 93-bit operands over a valid/ready stream and accumulates them in redundant (sum, carry) form, one operand per cycle. It then resolves the redundant pair with a chunked carry-propagate addition over several cycles and presents the binary sum on a valid/ready result port. It sits between the partial-product generator and the Montgomery reduction stage.

---
 rtl/csa_acc_pkg.sv | 15 +
 rtl/csa_acc_seq_if.sv | 31 +++
 rtl/csa_93.sv | 17 +
 rtl/csa_acc_seq.sv | 86 ++++++++
 tb/tb_csa_acc_seq.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and constants for the CSA accumulate/resolve sequencer.
//   W      : datapath width, fixed by the csa_93 instance
//   CNT_W  : operand count width
//   CHUNK  : bits resolved per cycle in the final carry-propagate add
//   NCHUNK : number of resolve cycles (W/CHUNK)
//   CIW    : width of the resolve chunk index
package csa_acc_pkg;
  localparam int W      = 93;
  localparam int CNT_W  = 8;
  localparam int CHUNK  = 31;
  localparam int NCHUNK = W / CHUNK;
  localparam int CIW    = $clog2(NCHUNK);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
endpackage

// File: rtl/csa_acc_seq_if.sv
// Job control, operand stream and result stream of csa_acc_seq.
//   master : job/operand producer and result consumer
//   slave  : the sequencer
//   start/num_ops/abort : job control
//   op_valid/op_ready/op_data : operand stream
//   res_valid/res_ready/res_data : result stream
//   busy : sequencer not idle
interface csa_acc_seq_if;
  import csa_acc_pkg::*;

  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             abort;
  logic             op_valid;
  logic [W-1:0]     op_data;
  logic             op_ready;
  logic             res_valid;
  logic [W-1:0]     res_data;
  logic             res_ready;
  logic             busy;

  modport master (
    output start, num_ops, abort, op_valid, op_data, res_ready,
    input  op_ready, res_valid, res_data, busy
  );

  modport slave (
    input  start, num_ops, abort, op_valid, op_data, res_ready,
    output op_ready, res_valid, res_data, busy
  );
endinterface

// File: rtl/csa_93.sv
// 93-bit 3:2 carry-save adder.
//   a, b, c : addends
//   s       : bitwise sum
//   cy      : carry vector, already shifted left (bit 0 = 0); the carry
//             out of the top bit is dropped, giving mod 2^W behaviour.
module csa_93
  import csa_acc_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);
  assign s  = a ^ b ^ c;
  assign cy = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
endmodule

// File: rtl/csa_acc_seq.sv
// Accumulates a programmed number of operands in carry-save form (one per
// cycle), then resolves the redundant pair CHUNK bits per cycle and offers
// the binary sum (mod 2^W) on the result stream.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of csa_acc_seq_if (job control, operands, result)
module csa_acc_seq
  import csa_acc_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  csa_acc_seq_if.slave bus
);
  state_t           state_q;
  logic [W-1:0]     s_q, c_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CIW-1:0]   chunk_q;
  logic             cy_q;

  logic [W-1:0]     csa_s, csa_c;
  logic [CHUNK-1:0] s_chunk, c_chunk;
  logic [CHUNK:0]   rsum;

  csa_93 u_csa (.a(s_q), .b(c_q), .c(bus.op_data), .s(csa_s), .cy(csa_c));

  // Ripple one chunk of the redundant pair, carrying between cycles via cy_q.
  always_comb begin
    s_chunk = s_q[chunk_q*CHUNK +: CHUNK];
    c_chunk = c_q[chunk_q*CHUNK +: CHUNK];
    rsum    = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};
  end

  assign bus.op_ready  = (state_q == ACCUM);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign bus.busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      chunk_q <= '0;
      cy_q    <= 1'b0;
    end else if (bus.abort) begin
      // Flush wins over any handshake in the same cycle.
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          s_q     <= '0;
          c_q     <= '0;
          res_q   <= '0;
          chunk_q <= '0;
          cy_q    <= 1'b0;
          cnt_q   <= bus.num_ops;
          // An empty job skips straight to resolving a zero pair.
          state_q <= (bus.num_ops == '0) ? RESOLVE : ACCUM;
        end
        ACCUM: if (bus.op_valid) begin
          s_q   <= csa_s;
          c_q   <= csa_c;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESOLVE;
            chunk_q <= '0;
            cy_q    <= 1'b0;
          end
        end
        RESOLVE: begin
          res_q[chunk_q*CHUNK +: CHUNK] <= rsum[CHUNK-1:0];
          cy_q    <= rsum[CHUNK];
          chunk_q <= chunk_q + 1'b1;
          if (chunk_q == CIW'(NCHUNK-1)) state_q <= DONE;
        end
        DONE: if (bus.res_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_acc_seq.sv
// Randomized self-checking bench for csa_acc_seq. The reference result of
// a job is the plain integer sum of its operands mod 2^W.
module tb_csa_acc_seq;
  import csa_acc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_acc_seq_if bus();
  csa_acc_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] ops_q[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_sum();
    logic [W-1:0] acc = '0;
    foreach (ops_q[i]) acc = acc + ops_q[i];
    return acc;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return W'(t[31:0]);
      default: return t[W-1:0];
    endcase
  endfunction

  // gap < 0 selects a random 0..2 cycle bubble between operands.
  task automatic do_job(input int n, input int gap, input int hold, input bit pulse_start,
                        input string tag);
    logic [W-1:0] exp;
    int lat, g;
    exp = model_sum();
    bus.start   = 1'b1;
    bus.num_ops = n[CNT_W-1:0];
    step;
    bus.start   = 1'b0;
    chk({tag, "_busy"}, W'(bus.busy), W'(1));
    for (int i = 0; i < n; i++) begin
      bus.op_valid = 1'b1;
      bus.op_data  = ops_q[i];
      chk({tag, "_rdy"}, W'(bus.op_ready), W'(1));
      step;
      bus.op_valid = 1'b0;
      bus.op_data  = rnd_op();
      if (i < n - 1) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin
          step;
          chk({tag, "_rdy_gap"}, W'(bus.op_ready), W'(1));
        end
      end
    end
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      step;
      lat++;
    end
    chk({tag, "_lat"}, W'(lat), W'(NCHUNK));
    chk({tag, "_data"}, bus.res_data, exp);
    for (int k = 0; k < hold; k++) begin
      bus.start = pulse_start & k[0];
      step;
      chk({tag, "_hold_vld"}, W'(bus.res_valid), W'(1));
      chk({tag, "_hold_data"}, bus.res_data, exp);
    end
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    step;
    bus.res_ready = 1'b0;
    chk({tag, "_vld_drop"}, W'(bus.res_valid), W'(0));
    chk({tag, "_idle"}, W'(bus.busy), W'(0));
  endtask

  initial begin
    bus.start = 1'b0; bus.num_ops = '0; bus.abort = 1'b0;
    bus.op_valid = 1'b0; bus.op_data = '0; bus.res_ready = 1'b0;

    #12;
    chk("rst_rdy",  W'(bus.op_ready),  W'(0));
    chk("rst_vld",  W'(bus.res_valid), W'(0));
    chk("rst_data", bus.res_data,      W'(0));
    chk("rst_busy", W'(bus.busy),      W'(0));
    rst_n = 1'b1;
    step;

    // 1+2+3, back-to-back operands
    ops_q.delete(); ops_q.push_back(W'(1)); ops_q.push_back(W'(2)); ops_q.push_back(W'(3));
    do_job(3, 0, 0, 1'b0, "sum123");

    // wrap mod 2^W with dropped MSB carry
    ops_q.delete(); ops_q.push_back('1); ops_q.push_back(W'(1));
    do_job(2, 0, 0, 1'b0, "wrap");

    // chunk-boundary carries with 2-cycle bubbles
    ops_q.delete();
    repeat (4) ops_q.push_back(W'(32'h7FFF_FFFF));
    chk("chunk_model", model_sum(), W'(36'h1_FFFF_FFFC));
    do_job(4, 2, 0, 1'b0, "chunk");

    // empty job, result held with start pulses ignored
    ops_q.delete();
    do_job(0, 0, 5, 1'b1, "zero");

    // abort concurrent with the third handshake
    bus.start = 1'b1; bus.num_ops = 8'd5;
    step;
    bus.start = 1'b0;
    bus.op_valid = 1'b1; bus.op_data = W'(1); step;
    bus.op_data = W'(2); step;
    bus.op_data = W'(3); bus.abort = 1'b1; step;
    bus.abort = 1'b0; bus.op_valid = 1'b0;
    chk("abort_busy", W'(bus.busy),      W'(0));
    chk("abort_rdy",  W'(bus.op_ready),  W'(0));
    chk("abort_vld",  W'(bus.res_valid), W'(0));
    chk("abort_data", bus.res_data,      W'(0));
    ops_q.delete(); ops_q.push_back(W'(8'h55));
    do_job(1, 0, 0, 1'b0, "post_abort");

    // asynchronous reset in the middle of RESOLVE
    bus.start = 1'b1; bus.num_ops = 8'd2;
    step;
    bus.start = 1'b0;
    bus.op_valid = 1'b1; bus.op_data = W'(5); step;
    bus.op_data = W'(7); step;
    bus.op_valid = 1'b0;
    step;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy",  W'(bus.op_ready),  W'(0));
    chk("arst_vld",  W'(bus.res_valid), W'(0));
    chk("arst_data", bus.res_data,      W'(0));
    chk("arst_busy", W'(bus.busy),      W'(0));
    #2 rst_n = 1'b1;
    step;
    ops_q.delete(); ops_q.push_back(W'(10)); ops_q.push_back(W'(20));
    do_job(2, 0, 0, 1'b0, "post_rst");

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 12);
      ops_q.delete();
      for (int i = 0; i < n; i++) ops_q.push_back(rnd_op());
      do_job(n, -1, $urandom_range(0, 3), 1'b1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
